// File: rtl/dma_slot_arbiter_pkg.sv
// agnus_pkg: shared owner encoding, fixed slot positions and line length for the chip-bus slot scheduler.
package agnus_pkg;
    localparam int HTOTAL = 453;
    localparam logic [2:0] OWN_NONE    = 3'd0;
    localparam logic [2:0] OWN_REFRESH = 3'd1;
    localparam logic [2:0] OWN_DISK    = 3'd2;
    localparam logic [2:0] OWN_AUDIO   = 3'd3;
    localparam logic [2:0] OWN_BPL     = 3'd4;
    localparam logic [2:0] OWN_SPRITE  = 3'd5;
    localparam logic [2:0] OWN_COPPER  = 3'd6;
    localparam logic [2:0] OWN_BUS     = 3'd7;
    localparam logic [3:0][7:0] REFRESH_SLOTS = {8'd7, 8'd5, 8'd3, 8'd1};
    localparam logic [7:0] DISK_FIRST   = 8'd9;
    localparam logic [7:0] AUDIO_FIRST  = 8'd15;
    localparam logic [7:0] SPRITE_FIRST = 8'd23;
    // Spans are measured in CCKs from the first slot; these channels use every other slot.
    localparam logic [7:0] DISK_SPAN   = 8'd6;
    localparam logic [7:0] AUDIO_SPAN  = 8'd8;
    localparam logic [7:0] SPRITE_SPAN = 8'd32;
    typedef struct packed {
        logic       valid;
        logic       sprite;
        logic [2:0] owner;
        logic [3:0] sub;
    } fixed_t;
endpackage

// File: rtl/dma_slot_arbiter_if.sv
// dma_slot_arbiter_if: beam position, DMACON enables, requests and slot grants between Agnus DMA engines and the arbiter.
interface dma_slot_arbiter_if;
    logic [8:0] hpos;
    logic       vbl;
    logic       vblend;
    logic       dmaen;
    logic       dsken;
    logic       spren;
    logic       copen;
    logic       blten;
    logic [3:0] auden;
    logic       blithog;
    logic       bpl_req;
    logic       cop_req;
    logic       blt_req;
    logic       cpu_req;
    logic [2:0] owner;
    logic [3:0] sub;
    logic       cpu_gnt;
    logic       blt_gnt;
    logic       slot_start;
    modport master (
        output hpos, vbl, vblend, dmaen, dsken, spren, copen, blten, auden,
               blithog, bpl_req, cop_req, blt_req, cpu_req,
        input  owner, sub, cpu_gnt, blt_gnt, slot_start
    );
    modport slave (
        input  hpos, vbl, vblend, dmaen, dsken, spren, copen, blten, auden,
               blithog, bpl_req, cop_req, blt_req, cpu_req,
        output owner, sub, cpu_gnt, blt_gnt, slot_start
    );
endinterface

// File: rtl/dma_slot_arbiter_decode.sv
// dma_fixed_slot_decode: maps a CCK slot index to its fixed owner (refresh, disk, audio, sprite) and sub-channel.
module dma_fixed_slot_decode
    import agnus_pkg::*;
(
    input  logic [7:0] i_slot,
    input  logic       i_dmaen,
    input  logic       i_dsken,
    input  logic       i_spren,
    input  logic       i_vbl,
    input  logic       i_vblend,
    input  logic [3:0] i_auden,
    output fixed_t     o_fix
);
    logic [7:0] w_dsk_off;
    logic [7:0] w_aud_off;
    logic [7:0] w_spr_off;
    logic       w_refresh;
    logic       w_disk;
    logic       w_audio;
    logic       w_sprite;
    always_comb begin
        w_dsk_off = i_slot - DISK_FIRST;
        w_aud_off = i_slot - AUDIO_FIRST;
        w_spr_off = i_slot - SPRITE_FIRST;
        w_refresh = (i_slot == REFRESH_SLOTS[0]) | (i_slot == REFRESH_SLOTS[1]) |
                    (i_slot == REFRESH_SLOTS[2]) | (i_slot == REFRESH_SLOTS[3]);
        w_disk    = i_dmaen & i_dsken & ~w_dsk_off[0] & (w_dsk_off < DISK_SPAN);
        w_audio   = i_dmaen & ~w_aud_off[0] & (w_aud_off < AUDIO_SPAN) & i_auden[w_aud_off[2:1]];
        // Sprites fetch only outside vertical blanking, plus its final line to preload the first row.
        w_sprite  = i_dmaen & i_spren & (~i_vbl | i_vblend) & ~w_spr_off[0] & (w_spr_off < SPRITE_SPAN);
        o_fix.valid  = w_refresh | w_disk | w_audio | w_sprite;
        o_fix.sprite = w_sprite;
        o_fix.owner  = w_refresh ? OWN_REFRESH : w_disk ? OWN_DISK : w_audio ? OWN_AUDIO :
                       w_sprite ? OWN_SPRITE : OWN_NONE;
        o_fix.sub    = w_audio ? {2'b00, w_aud_off[2:1]} : w_sprite ? w_spr_off[4:1] : 4'd0;
    end
endmodule

// File: rtl/dma_slot_arbiter.sv
// dma_slot_arbiter: per-CCK chip-bus slot scheduler; fixed DMA slots first, then bitplane > copper > blitter > CPU.
// DMA_ARB_STARVE_EN compiles in the blitter-vs-CPU starvation counter; undefined, the blitter always wins.
module dma_slot_arbiter #(
    parameter int HTOTAL       = agnus_pkg::HTOTAL,
    parameter int STARVE_LIMIT = 3
) (
    input logic               clk,
    input logic               _reset,
    dma_slot_arbiter_if.slave bus
);
    import agnus_pkg::*;
    logic       w_decide;
    logic [7:0] w_slot_next;
    fixed_t     w_fix;
    logic       w_bpl;
    logic       w_cop;
    logic       w_blt;
    logic       w_hard;
    logic       w_force;
    logic       w_blt_win;
    logic       w_cpu_win;
    logic [2:0] w_owner;
    logic [3:0] w_sub;
    logic [2:0] r_owner;
    logic [3:0] r_sub;
    logic       r_cpu_gnt;
    logic       r_blt_gnt;
    logic       r_slot_start;
    assign w_decide    = bus.hpos[0];
    assign w_slot_next = (bus.hpos == 9'(HTOTAL)) ? 8'd0 : bus.hpos[8:1] + 8'd1;
    dma_fixed_slot_decode u_decode (
        .i_slot   (w_slot_next),
        .i_dmaen  (bus.dmaen),
        .i_dsken  (bus.dsken),
        .i_spren  (bus.spren),
        .i_vbl    (bus.vbl),
        .i_vblend (bus.vblend),
        .i_auden  (bus.auden),
        .o_fix    (w_fix)
    );
    always_comb begin
        w_bpl     = bus.bpl_req & bus.dmaen;
        w_cop     = bus.cop_req & bus.dmaen & bus.copen & ~w_slot_next[0];
        w_blt     = bus.blt_req & bus.dmaen & bus.blten;
        // Bitplane fetches may steal sprite slots but never refresh, disk or audio.
        w_hard    = w_fix.valid & ~(w_fix.sprite & w_bpl);
        w_owner   = w_hard ? w_fix.owner : w_bpl ? OWN_BPL : w_cop ? OWN_COPPER :
                    (w_blt | bus.cpu_req) ? OWN_BUS : OWN_NONE;
        w_sub     = w_hard ? w_fix.sub : 4'd0;
        w_blt_win = (w_owner == OWN_BUS) & w_blt & ~w_force;
        w_cpu_win = (w_owner == OWN_BUS) & ~w_blt_win;
    end
`ifdef DMA_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] r_starve;
    assign w_force = w_blt & bus.cpu_req & ~bus.blithog & (r_starve >= LIMIT);
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)
            r_starve <= '0;
        else if (~bus.cpu_req | bus.blithog | (w_decide & w_cpu_win))
            r_starve <= '0;
        else if (w_decide & w_blt_win)
            r_starve <= r_starve + 1'b1;
    end
`else
    logic w_unused;
    assign w_force  = 1'b0;
    assign w_unused = bus.blithog;
`endif
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_owner      <= OWN_NONE;
            r_sub        <= 4'd0;
            r_cpu_gnt    <= 1'b0;
            r_blt_gnt    <= 1'b0;
            r_slot_start <= 1'b0;
        end else begin
            r_slot_start <= w_decide;
            if (w_decide) begin
                r_owner   <= w_owner;
                r_sub     <= w_sub;
                r_cpu_gnt <= w_cpu_win;
                r_blt_gnt <= w_blt_win;
            end
        end
    end
    assign bus.owner      = r_owner;
    assign bus.sub        = r_sub;
    assign bus.cpu_gnt    = r_cpu_gnt;
    assign bus.blt_gnt    = r_blt_gnt;
    assign bus.slot_start = r_slot_start;
endmodule

// File: tb/tb_dma_slot_arbiter.sv
// tb_dma_slot_arbiter: vector table, hand sequences and random lines against a slot-rule reference model.
module tb_dma_slot_arbiter;
    import agnus_pkg::*;
    localparam int LIM = 3;
`ifdef DMA_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    dma_slot_arbiter_if bus ();
    dma_slot_arbiter #(.HTOTAL(HTOTAL), .STARVE_LIMIT(LIM)) dut (
        .clk    (clk),
        ._reset (rst_n),
        .bus    (bus)
    );
    typedef struct {
        int slot;
        int dmaen, dsken, spren, copen, blten, auden, vbl, vblend;
        int bpl, cop, blt, cpu, hog;
        int owner, sub, cg, bg;
    } vec_t;
    int n_chk = 0;
    int n_fail = 0;
    logic [2:0] m_owner = '0;
    logic [3:0] m_sub = '0;
    logic m_cg = 1'b0, m_bg = 1'b0, m_ss = 1'b0;
    int m_starve = 0;
    function automatic logic [15:0] outs();
        return {6'd0, bus.owner, bus.sub, bus.cpu_gnt, bus.blt_gnt, bus.slot_start};
    endfunction
    function automatic logic [15:0] pack(logic [2:0] o, logic [3:0] s, logic c, logic b, logic ss);
        return {6'd0, o, s, c, b, ss};
    endfunction
    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Reference: who owns slot s given the current inputs and the count of consecutive blitter wins.
    task automatic ref_slot(input int s, input int cnt, output logic [2:0] o, output logic [3:0] sb,
                            output logic cg, output logic bg);
        bit dma = bus.dmaen;
        o = 3'd0; sb = 4'd0; cg = 1'b0; bg = 1'b0;
        if (s inside {1, 3, 5, 7}) o = 3'd1;
        else if (dma && bus.dsken && s inside {9, 11, 13}) o = 3'd2;
        else if (dma && s >= 15 && s <= 21 && s % 2 == 1 && bus.auden[(s - 15) / 2]) begin
            o = 3'd3; sb = 4'((s - 15) / 2);
        end
        else if (dma && bus.bpl_req) o = 3'd4;
        else if (dma && bus.spren && (!bus.vbl || bus.vblend) && s >= 23 && s <= 53 && s % 2 == 1) begin
            o = 3'd5; sb = 4'((s - 23) / 2);
        end
        else if (dma && bus.copen && bus.cop_req && s % 2 == 0) o = 3'd6;
        else if (dma && bus.blten && bus.blt_req && !(STARVE_EN && bus.cpu_req && !bus.blithog && cnt >= LIM)) begin
            o = 3'd7; bg = 1'b1;
        end
        else if (bus.cpu_req) begin
            o = 3'd7; cg = 1'b1;
        end
    endtask
    task automatic clk_step();
        int s;
        logic [2:0] o;
        logic [3:0] sb;
        logic cg, bg;
        if (bus.hpos[0]) begin
            s = (bus.hpos == 9'(HTOTAL)) ? 0 : int'(bus.hpos) / 2 + 1;
            ref_slot(s, m_starve, o, sb, cg, bg);
            m_owner = o; m_sub = sb; m_cg = cg; m_bg = bg;
            if (cg || !bus.cpu_req || bus.blithog) m_starve = 0;
            else if (bg) m_starve++;
        end else if (!bus.cpu_req || bus.blithog) m_starve = 0;
        m_ss = bus.hpos[0];
        @(negedge clk);
    endtask
    task automatic set_idle();
        {bus.vbl, bus.vblend, bus.dmaen, bus.dsken, bus.spren, bus.copen, bus.blten} = '0;
        {bus.blithog, bus.bpl_req, bus.cop_req, bus.blt_req, bus.cpu_req} = '0;
        bus.auden = 4'd0;
    endtask
    task automatic apply(input vec_t v, input int idx);
        int dec = (v.slot == 0) ? HTOTAL : 2 * v.slot - 1;
        set_idle();
        bus.hpos = 9'(dec - 1);
        clk_step();
        bus.dmaen = 1'(v.dmaen); bus.dsken = 1'(v.dsken); bus.spren = 1'(v.spren);
        bus.copen = 1'(v.copen); bus.blten = 1'(v.blten); bus.auden = 4'(v.auden);
        bus.vbl = 1'(v.vbl); bus.vblend = 1'(v.vblend); bus.bpl_req = 1'(v.bpl);
        bus.cop_req = 1'(v.cop); bus.blt_req = 1'(v.blt); bus.cpu_req = 1'(v.cpu); bus.blithog = 1'(v.hog);
        bus.hpos = 9'(dec);
        clk_step();
        cmp($sformatf("vec%0d_grant", idx), outs(), pack(3'(v.owner), 4'(v.sub), 1'(v.cg), 1'(v.bg), 1'b1));
        set_idle();
        bus.hpos = 9'((dec == HTOTAL) ? 0 : dec + 1);
        clk_step();
        cmp($sformatf("vec%0d_hold", idx), outs(), pack(3'(v.owner), 4'(v.sub), 1'(v.cg), 1'(v.bg), 1'b0));
    endtask
    initial begin
        vec_t vt[$];
        int h;
        logic exp_c;
        //          slot dma dsk spr cop blt aud vbl vbe bpl cr  br  cpu hog own sub cg bg
        vt.push_back('{2,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 0});
        vt.push_back('{3,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0});
        vt.push_back('{0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 0});
        vt.push_back('{15, 1, 0, 0, 0, 0, 5,  0, 0, 0, 0, 0, 1, 0, 3, 0,  0, 0});
        vt.push_back('{19, 1, 0, 0, 0, 0, 5,  0, 0, 0, 0, 0, 1, 0, 3, 2,  0, 0});
        vt.push_back('{17, 1, 0, 0, 0, 0, 5,  0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 0});
        vt.push_back('{21, 1, 0, 0, 0, 0, 5,  0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 0});
        vt.push_back('{23, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
        vt.push_back('{23, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 5, 0,  0, 0});
        vt.push_back('{51, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 5, 14, 0, 0});
        vt.push_back('{53, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5, 15, 0, 0});
        vt.push_back('{23, 1, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 4, 0,  0, 0});
        vt.push_back('{31, 1, 0, 0, 1, 1, 0,  0, 0, 0, 1, 1, 0, 0, 7, 0,  0, 1});
        vt.push_back('{32, 1, 0, 0, 1, 1, 0,  0, 0, 0, 1, 1, 0, 0, 6, 0,  0, 0});
        vt.push_back('{11, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 0,  0, 0});
        vt.push_back('{11, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
        vt.push_back('{13, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 7, 0,  1, 0});
        vt.push_back('{40, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 7, 0,  1, 0});
        vt.push_back('{60, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 7, 0,  0, 1});
        vt.push_back('{7,  1, 1, 1, 1, 1, 15, 0, 0, 1, 1, 1, 1, 0, 1, 0,  0, 0});
        vt.push_back('{9,  1, 1, 1, 1, 1, 15, 0, 0, 1, 1, 1, 1, 0, 2, 0,  0, 0});
        vt.push_back('{0,  1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 1, 0, 6, 0,  0, 0});
        set_idle();
        bus.hpos = 9'd0;
        repeat (3) @(negedge clk);
        cmp("reset_state", outs(), 16'd0);
        rst_n = 1'b1;
        foreach (vt[i]) apply(vt[i], i);
        // Copper held across an odd slot waits for the even one and beats the blitter there.
        set_idle();
        bus.dmaen = 1'b1; bus.copen = 1'b1; bus.blten = 1'b1; bus.cop_req = 1'b1; bus.blt_req = 1'b1;
        for (int hp = 56; hp <= 60; hp++) begin
            bus.hpos = 9'(hp);
            clk_step();
            if (hp == 57) cmp("cop_odd", outs(), pack(3'd7, 4'd0, 1'b0, 1'b1, 1'b1));
            if (hp == 59) cmp("cop_even", outs(), pack(3'd6, 4'd0, 1'b0, 1'b0, 1'b1));
            if (hp == 60) cmp("cop_hold", outs(), pack(3'd6, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        for (int hog = 0; hog < 2; hog++) begin
            set_idle();
            bus.hpos = 9'd118;
            clk_step();
            bus.dmaen = 1'b1; bus.blten = 1'b1; bus.blt_req = 1'b1; bus.cpu_req = 1'b1; bus.blithog = 1'(hog);
            for (int k = 0; k < 16; k++) begin
                bus.hpos = 9'(119 + k);
                clk_step();
                if (k % 2 == 0) begin
                    exp_c = STARVE_EN && hog == 0 && (k / 2) % 4 == 3;
                    cmp($sformatf("starve_hog%0d_%0d", hog, k / 2), 16'({bus.cpu_gnt, bus.blt_gnt}), 16'({exp_c, !exp_c}));
                end
            end
        end
        set_idle();
        bus.dmaen = 1'b1; bus.blten = 1'b1; bus.blt_req = 1'b1;
        for (int hp = 96; hp <= 99; hp++) begin
            bus.hpos = 9'(hp);
            clk_step();
        end
        cmp("rst_pre_grant", outs(), pack(3'd7, 4'd0, 1'b0, 1'b1, 1'b1));
        bus.hpos = 9'd100;
        @(posedge clk);
        #2;
        cmp("rst_mid_slot", outs(), pack(3'd7, 4'd0, 1'b0, 1'b1, 1'b0));
        rst_n = 1'b0;
        #1;
        cmp("rst_async_clear", outs(), 16'd0);
        @(negedge clk);
        bus.hpos = 9'd101;
        @(negedge clk);
        cmp("rst_held", outs(), 16'd0);
        m_owner = '0; m_sub = '0; m_cg = 1'b0; m_bg = 1'b0; m_ss = 1'b0; m_starve = 0;
        rst_n = 1'b1;
        bus.hpos = 9'd102;
        clk_step();
        cmp("rst_release_even", outs(), 16'd0);
        bus.hpos = 9'd103;
        clk_step();
        cmp("rst_first_grant", outs(), pack(3'd7, 4'd0, 1'b0, 1'b1, 1'b1));
        h = 0;
        for (int i = 0; i < 2 * (HTOTAL + 1); i++) begin
            bus.hpos = 9'(h);
            bus.dmaen = 1'($urandom_range(0, 7) != 0);
            bus.dsken = 1'($urandom_range(0, 1));
            bus.spren = 1'($urandom_range(0, 1));
            bus.copen = 1'($urandom_range(0, 1));
            bus.blten = 1'($urandom_range(0, 3) != 0);
            bus.auden = 4'($urandom_range(0, 15));
            bus.vbl = 1'($urandom_range(0, 1));
            bus.vblend = 1'($urandom_range(0, 1));
            bus.bpl_req = 1'($urandom_range(0, 3) == 0);
            bus.cop_req = 1'($urandom_range(0, 2) == 0);
            bus.blt_req = 1'($urandom_range(0, 3) != 0);
            bus.cpu_req = 1'($urandom_range(0, 7) != 0);
            bus.blithog = 1'($urandom_range(0, 7) == 0);
            clk_step();
            cmp($sformatf("rand_i%0d_h%0d", i, h), outs(), pack(m_owner, m_sub, m_cg, m_bg, m_ss));
            h = (h == HTOTAL) ? 0 : h + 1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_slot_arbiter.md
# dma_slot_arbiter

Chip-bus slot scheduler for Agnus. It uses the horizontal beam position to divide every video line into colour-clock (CCK) slots and grants each slot to one owner. Fixed slots go to refresh, disk, audio and sprite DMA, and a fixed priority decides the remaining slots between bitplane, copper, blitter and CPU. It sits between the beam counter and the DMA engines and drives the chip-RAM address/strobe mux.

## Interface
Parameters:
- HTOTAL, 453: last hpos value of a line (227 CCKs × 2 − 1).
- STARVE_LIMIT, 3: consecutive blitter grants with CPU waiting before the CPU is forced in.

Ports:
- clk  in  1  bus clock (one hpos tick per clk)
- _reset  in  1  asynchronous active-low reset
- hpos  in  9  horizontal beam counter, 0..HTOTAL
- vbl  in  1  vertical blanking active
- vblend  in  1  last vertical blanking line
- dmaen, dsken, spren, copen, blten  in  1 each  DMACON enables
- auden  in  4  audio channel DMA enables
- blithog  in  1  blitter-nasty (BLTPRI)
- bpl_req  in  1  bitplane sequencer wants the next slot
- cop_req, blt_req, cpu_req  in  1 each  requests, level-held until granted
- owner  out  3  granted owner: 0 none, 1 refresh, 2 disk, 3 audio, 4 bitplane, 5 sprite, 6 copper, 7 blitter/cpu (see cpu_gnt)
- sub  out  4  audio channel 0..3, or sprite {index[2:0], word}
- cpu_gnt  out  1  slot granted to CPU (owner=7)
- blt_gnt  out  1  slot granted to blitter (owner=7)
- slot_start  out  1  first clk of a new slot

## Operation
- Slot index c = hpos[8:1], 0..226.
- Decision is made on the clk where hpos[0]=1, for slot c+1. It wraps to slot 0 when hpos=HTOTAL.
- The decision is registered and held for both clks of that slot.
- Fixed slots, independent of requests:
  - refresh: c ∈ {1,3,5,7}.
  - disk: c ∈ {9,11,13} when dmaen&dsken.
  - audio k: c = 15+2k when dmaen&auden[k]; sub=k.
  - sprite n, word w: c = 23+4n+2w when dmaen&spren and (!vbl|vblend); sub={n,w}.
- Remaining slots, first match wins:
  1. bitplane when bpl_req&dmaen (this also steals a sprite slot).
  2. copper when cop_req&dmaen&copen and c+1 is even.
  3. blitter when blt_req&dmaen&blten, unless starvation forces the CPU.
  4. CPU when cpu_req.
  5. Otherwise none (owner=0).
- Starvation counter:
  - Increments on each blitter grant while cpu_req=1 and blithog=0.
  - Clears on any CPU grant, when cpu_req=0, or when blithog=1.
  - When it reaches STARVE_LIMIT, the next arbitrated slot that the blitter would take goes to the CPU, and the counter clears.
- Disabling dmaen mid-line affects only decisions made after the change. The current slot completes.
- cpu_req and blt_req are never both granted. cpu_gnt and blt_gnt are mutually exclusive.

## Timing
- Reset values: owner=0, sub=0, cpu_gnt=0, blt_gnt=0, slot_start=0, starvation counter=0.
- Latency: request sampled on the hpos[0]=1 clk → grant visible on the next clk, for 2 clks.
- slot_start=1 on the clk where owner updates, i.e. hpos[0]=0 next.
- Requests that drop before the decision clk are ignored. Requests that drop after the decision keep the grant for the slot.
- Line wrap: at hpos=HTOTAL the decision is for slot 0, which is arbitrated (not fixed).
- Async reset mid-slot: outputs clear immediately. The first grant follows the first hpos[0]=1 clk after release.

## Configuration
- DMA_ARB_STARVE_EN:
  - Defined: the starvation counter and forced CPU slot are compiled in.
  - Undefined: the counter is absent. The blitter always beats the CPU when requesting, and blithog is ignored.

## Structure
- Shared package (agnus_pkg) holds:
  - owner encoding constants;
  - fixed slot positions (REFRESH_SLOTS, DISK_FIRST=9, AUDIO_FIRST=15, SPRITE_FIRST=23);
  - HTOTAL.
- Sub-module dma_fixed_slot_decode: combinational map from c to fixed owner/sub and enables. The arbiter wraps it with the priority logic, registers and counter.

## Test plan
- Idle line with all enables 0 and cpu_req=1: owner=7, cpu_gnt=1 in every slot except refresh (1,3,5,7). Refresh slots show owner=1.
- auden=4'b0101, dmaen=1: slot 15 gives owner=3/sub=0 and slot 19 gives owner=3/sub=2. Slots 17 and 21 fall through to CPU.
- spren=1, vbl=1, vblend=0: no sprite slots. Then vblend=1: slot 23 gives owner=5/sub=0, and slot 51 gives sub={7,0}.
- cop_req held, c+1 odd: copper is not granted until the next even slot. There owner=6, even with blt_req=1.
- With DMA_ARB_STARVE_EN, blt_req=cpu_req=1, blithog=0: the grant pattern on free slots is B,B,B,C,B,B,B,C. With blithog=1 or the macro undefined, the pattern is all B.
- _reset asserted at hpos=100 during a blitter grant: all outputs go to 0 on the same clk. After release, the first grant follows the next hpos[0]=1 clk.
